// File: rtl/bcd_chain_timer.sv
// rtl/bcd_chain_timer.sv - cascaded BCD time counter with per-digit modulus, lap snapshot and display mux
// Digit 0 is least significant; MOD6_MASK bit i selects a 0..5 digit instead of 0..9.
module bcd_chain_timer #(
  parameter int                DIGITS    = 8,
  parameter int                SEL_W     = 3,
  parameter logic [DIGITS-1:0] MOD6_MASK = DIGITS'(8'b0101_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  run,
  input  logic                  tick,
  input  logic                  down,
  input  logic                  lap,
  input  logic                  lap_show,
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [3:0]            out,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  zero
);

  logic [4*DIGITS-1:0] snap;
  logic [4*DIGITS-1:0] nxt;
  logic [4*DIGITS-1:0] src;
  logic                carry;

  function automatic logic [3:0] dmax(input int i);
    return MOD6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  // Ripple the step through the chain; carry ends high only if every digit advanced.
  always_comb begin
    nxt   = count;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (down)
          nxt[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? dmax(i) : count[4*i +: 4] - 4'd1;
        else
          nxt[4*i +: 4] = (count[4*i +: 4] >= dmax(i)) ? 4'd0 : count[4*i +: 4] + 4'd1;
      end
      carry = carry & (down ? (count[4*i +: 4] == 4'd0) : (count[4*i +: 4] >= dmax(i)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (run && tick) begin
      count <= nxt;
      wrap  <= carry;
    end else begin
      wrap  <= 1'b0;
    end
  end

  // Snapshot captures the pre-edge count independent of clr/load/step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      snap <= '0;
    else if (lap)
      snap <= count;
  end

  assign zero = (count == '0);
  assign src  = lap_show ? snap : count;

  always_comb begin
    out = 4'hF;
    if (en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel == SEL_W'(i))
          out = src[4*i +: 4];
      end
    end
  end

endmodule

// File: tb/tb_bcd_chain_timer.sv
// tb/tb_bcd_chain_timer.sv - directed and randomized checks of bcd_chain_timer against a digit-array model
`timescale 1ns/1ps
module tb_bcd_chain_timer;

  logic        clk = 1'b0;
  logic        rst, clr, load, run, tick, down, lap, lap_show, en;
  logic [31:0] load_val;
  logic [2:0]  sel;
  logic [3:0]  out, out6;
  logic [31:0] count;
  logic [23:0] count6;
  logic        wrap, zero, wrap6, zero6;

  int checks = 0;
  int errors = 0;

  int          md[8];
  logic [31:0] msnap;
  logic        mwrap;

  always #10 clk = ~clk;

  bcd_chain_timer dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .run(run), .tick(tick), .down(down), .lap(lap), .lap_show(lap_show),
    .en(en), .sel(sel), .out(out), .count(count), .wrap(wrap), .zero(zero)
  );

  bcd_chain_timer #(.DIGITS(6), .SEL_W(3), .MOD6_MASK(6'b01_0000)) dut6 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[23:0]),
    .run(run), .tick(tick), .down(down), .lap(lap), .lap_show(lap_show),
    .en(en), .sel(sel), .out(out6), .count(count6), .wrap(wrap6), .zero(zero6)
  );

  function automatic int dmax(input int i);
    return (i == 4 || i == 6) ? 5 : 9;
  endfunction

  function automatic logic [31:0] mpack();
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'(md[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counting as multi-digit add/subtract with carry/borrow.
  task automatic model_edge(input logic c, input logic l, input logic [31:0] lv,
                            input logic r, input logic t, input logic d, input logic lp);
    int carry;
    if (lp) msnap = mpack();
    mwrap = 1'b0;
    if (c) begin
      for (int i = 0; i < 8; i++) md[i] = 0;
    end else if (l) begin
      for (int i = 0; i < 8; i++) md[i] = int'(lv[4*i +: 4]);
    end else if (r && t) begin
      carry = 1;
      for (int i = 0; i < 8 && carry != 0; i++) begin
        if (!d) begin
          md[i] = md[i] + 1;
          if (md[i] > dmax(i)) md[i] = 0; else carry = 0;
        end else begin
          md[i] = md[i] - 1;
          if (md[i] < 0) md[i] = dmax(i); else carry = 0;
        end
      end
      mwrap = (carry != 0);
    end
  endtask

  task automatic do_edge(input logic c, input logic l, input logic [31:0] lv,
                         input logic r, input logic t, input logic d, input logic lp);
    clr = c; load = l; load_val = lv; run = r; tick = t; down = d; lap = lp;
    model_edge(c, l, lv, r, t, d, lp);
    @(posedge clk);
    #1;
    chk("count", count, mpack());
    chk("wrap", {31'b0, wrap}, {31'b0, mwrap});
    chk("zero", {31'b0, zero}, {31'b0, mpack() == 32'd0});
  endtask

  task automatic idle();
    do_edge(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input logic e, input logic ls, input logic [2:0] s);
    logic [31:0] v;
    logic [3:0]  exp;
    en = e; lap_show = ls; sel = s;
    #1;
    v   = ls ? msnap : mpack();
    exp = e ? v[4*s +: 4] : 4'hF;
    chk("out", {28'b0, out}, {28'b0, exp});
  endtask

  function automatic logic [31:0] rand_val(input logic near_top);
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) begin
      if (near_top && i > 0)        v[4*i +: 4] = 4'(dmax(i));
      else if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
      else                          v[4*i +: 4] = 4'($urandom_range(0, dmax(i)));
    end
    return v;
  endfunction

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; run = 1'b0; tick = 1'b0;
    down = 1'b0; lap = 1'b0; lap_show = 1'b0; en = 1'b1; sel = 3'd0;
    for (int i = 0; i < 8; i++) md[i] = 0;
    msnap = '0; mwrap = 1'b0;
    #2;
    chk("rst_count", count, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_out", {28'b0, out}, 32'h0);
    chk("rst_count6", {8'b0, count6}, 32'h0);
    chk("rst_wrap6", {31'b0, wrap6}, 32'd0);
    chk("rst_zero6", {31'b0, zero6}, 32'd1);
    #10 rst = 1'b1;

    // Asynchronous reset mid-count
    do_edge(1'b0, 1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", count, 32'h0);
    chk("arst_wrap", {31'b0, wrap}, 32'd0);
    chk("arst_zero", {31'b0, zero}, 32'd1);
    chk("arst_out", {28'b0, out}, 32'h0);
    for (int i = 0; i < 8; i++) md[i] = 0;
    msnap = '0;
    #2 rst = 1'b1;

    // Carries including mod-6 digit 4
    do_edge(1'b0, 1'b1, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("up_09", count, 32'h0000_0010);
    do_edge(1'b0, 1'b1, 32'h0005_9999, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("up_59999", count, 32'h0010_0000);

    // Full-chain up wrap, then one-cycle pulse
    do_edge(1'b0, 1'b1, 32'h9595_9999, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("upwrap_count", count, 32'h0);
    chk("upwrap_pulse", {31'b0, wrap}, 32'd1);
    idle();
    chk("upwrap_end", {31'b0, wrap}, 32'd0);

    // Down wrap then ordinary down step
    do_edge(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("dnwrap_count", count, 32'h9595_9999);
    chk("dnwrap_pulse", {31'b0, wrap}, 32'd1);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("dn_next", count, 32'h9595_9998);

    // Out-of-range loaded digit
    do_edge(1'b0, 1'b1, 32'h0007_9999, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_edge(1'b0, 1'b1, 32'h0007_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Lap concurrent with step, then clear leaves snapshot
    do_edge(1'b0, 1'b1, 32'h0000_0123, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("lap_count", count, 32'h0000_0124);
    chk_out(1'b1, 1'b1, 3'd0);
    chk("lap_out_snap", {28'b0, out}, 32'd3);
    chk_out(1'b1, 1'b0, 3'd0);
    chk("lap_out_live", {28'b0, out}, 32'd4);
    do_edge(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) chk_out(1'b1, 1'b1, 3'(s));
    chk_out(1'b1, 1'b1, 3'd2);
    chk("snap_kept", {28'b0, out}, 32'd1);

    // Display blanking and 6-digit out-of-range select
    do_edge(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) chk_out(1'b0, 1'b0, 3'(s));
    chk_out(1'b1, 1'b0, 3'd7);
    chk("d6_sel7", {28'b0, out6}, 32'hF);
    chk_out(1'b1, 1'b0, 3'd6);
    chk("d6_sel6", {28'b0, out6}, 32'hF);
    chk_out(1'b1, 1'b0, 3'd5);
    chk("d6_sel5", {28'b0, out6}, 32'h3);

    // run=0 drops ticks
    for (int k = 0; k < 4; k++) do_edge(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hold", count, 32'h1234_5678);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic c, l, r, t, d, lp;
      int op;
      op = int'($urandom_range(0, 15));
      c  = (op == 0);
      l  = (op >= 1 && op <= 2);
      r  = ($urandom_range(0, 3) != 0);
      t  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1) != 0;
      lp = ($urandom_range(0, 7) == 0);
      do_edge(c, l, rand_val(op == 2), r, t, d, lp);
      chk_out($urandom_range(0, 5) != 0, $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_chain_timer.md
Name: bcd_chain_timer

Overview:
Parametrised cascaded BCD time counter with a per-digit modulus (mod-10 or mod-6), up/down counting, synchronous load/clear, lap snapshot and a digit-select display mux. Digit 0 is least significant. Default configuration is an 8-digit stopwatch chain whose digits 4 and 6 are mod-6. Sits between the tick prescaler and the 7-segment scan driver. The scan driver consumes out/sel; the tick source drives tick.

Parameters:
DIGITS, 8, number of BCD digits in the chain (2..16).
SEL_W, 3, width of sel; must satisfy 2**SEL_W >= DIGITS.
MOD6_MASK, 8'b0101_0000 (width DIGITS), bit i=1 makes digit i mod-6 (max 5), otherwise mod-10 (max 9).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of live count
load  in  1  synchronous load of load_val into live count
load_val  in  4*DIGITS  BCD load value, digit i at [4i+3:4i]
run  in  1  count enable level (0 = stopped/hold)
tick  in  1  one-cycle step strobe
down  in  1  direction: 0 up, 1 down
lap  in  1  capture live count into snapshot register
lap_show  in  1  display source: 0 live, 1 snapshot
en  in  1  display enable
sel  in  SEL_W  digit select for out
out  out  4  selected digit, 4'hF when blanked
count  out  4*DIGITS  live count, registered
wrap  out  1  one-cycle pulse on full-chain rollover
zero  out  1  live count is all zeros (combinational)

Behaviour:
- Reset (rst=0, async): count=0, snapshot=0, wrap=0; zero=1 and out=0 (if en=1, sel<DIGITS) with no clock edge needed.
- Live-count update priority per edge: clr > load > step. Step occurs when run=1 and tick=1; no step otherwise.
- max(i) = 5 if MOD6_MASK[i], else 9. A digit is at_top when value >= max(i) and at_bottom when value == 0.
- Up step: digit 0 always advances. Digit i>0 advances only when all lower digits are at_top. Advancing an at_top digit sets it to 0; otherwise it increments by 1.
- Down step: digit 0 always advances. Digit i>0 advances only when all lower digits are at_bottom. Advancing an at_bottom digit sets it to max(i); otherwise it decrements by 1.
- Load writes load_val verbatim; out-of-range digits (e.g. 7 in a mod-6 digit) are not corrected. The next up-step that advances such a digit sets it to 0; a down-step decrements it normally.
- wrap is registered and high for exactly the cycle after a step where every digit advanced, i.e. all at_top going up or all at_bottom going down. wrap is 0 on clr/load cycles.
- down is sampled at each step edge; changing direction needs no idle cycle.
- lap=1 captures the pre-edge live count into the snapshot register, regardless of clr/load/step on the same edge. The snapshot is unaffected by clr and load.
- Display mux (combinational): source = snapshot if lap_show else count. out = 4'hF if en=0 or sel >= DIGITS, else source digit[sel].
- run=0 freezes count; tick strobes are dropped, not queued.
- Latency: count, wrap and snapshot reflect inputs one clock after the edge. out and zero follow count/snapshot/sel combinationally.

Test Plan:
1. Apply clk, drive rst=0 mid-count at count=0x00000042 -> count=0 and wrap=0 asynchronously; with en=1, sel=0, out=0 before any edge.
2. load 0x00000009 then one up step -> 0x00000010; load 0x00059999 then one up step -> 0x00100000 (digit 4 mod-6 wraps, digit 5 increments).
3. load 0x95959999, up step -> count=0x00000000, wrap=1 for exactly one cycle, then 0; zero=1.
4. load 0, down=1 step -> 0x95959999 with a wrap pulse; next down step -> 0x95959998, wrap=0.
5. At count=0x00000123 assert lap, run and tick on the same edge -> snapshot=0x123, count=0x124. With lap_show=1, sel=0 -> out=3; with lap_show=0 -> out=4. Assert clr -> count=0, snapshot stays 0x123.
6. Display mux: en=0 -> out=4'hF for every sel; en=1 with DIGITS=6 and sel=7 -> 4'hF. Apply run=0 with tick pulses -> count unchanged.
